// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, rstatus codes and writeback entry type for the ALU writeback stage
package alu_pkg;
    localparam int XLEN = 32;
    localparam int RIDX_W = 5;
    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam int RSTATUS = 30;
    localparam int ADD_EXC_CODE = 1;
    localparam int SUB_EXC_CODE = 3;
    typedef struct packed {
        logic we;
        logic exc;
        logic ne;
        logic lt;
        logic [RIDX_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_entry;
endpackage

// File: rtl/wb_skid_fifo.sv
// wb_skid_fifo: 2-entry circular valid/ready buffer of writeback entries
module wb_skid_fifo
    import alu_pkg::*;
#(
    parameter type T = wb_entry
) (
    input  logic clock,
    input  logic reset_n,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);
    T mem [2];
    logic [1:0] count;
    logic wr_ptr, rd_ptr, push, pop;
    assign in_ready = count != 2'd2;
    assign out_valid = count != 2'd0;
    assign out_data = mem[rd_ptr];
    assign push = in_valid && in_ready;
    assign pop = out_valid && out_ready;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) mem[wr_ptr] <= in_data;
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: registers ALU results, maps overflow to rstatus writes, skid-buffers for a stalled consumer
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int REG_W = RIDX_W,
    parameter logic [REG_W-1:0] RSTATUS_REG = REG_W'(RSTATUS),
    parameter logic [DATA_W-1:0] ADD_EXC = DATA_W'(ADD_EXC_CODE),
    parameter logic [DATA_W-1:0] SUB_EXC = DATA_W'(SUB_EXC_CODE),
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [DATA_W-1:0] data_result,
    input  logic              overflow,
    input  logic              isNotEqual,
    input  logic              isLessThan,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_we,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_ne,
    output logic              wb_lt,
    output logic              wb_exc,
    output logic [CNT_W-1:0]  ovf_count
);
    wb_entry entry, head;
    logic add_ovf, sub_ovf, exc, push;
    assign add_ovf = overflow && in_opcode == OP_ADD;
    assign sub_ovf = overflow && in_opcode == OP_SUB;
    assign exc = add_ovf || sub_ovf;
    assign push = in_valid && in_ready;
    always_comb begin
        entry.exc = exc;
        entry.ne = isNotEqual;
        entry.lt = isLessThan;
        entry.rd = exc ? RSTATUS_REG : in_rd;
        entry.data = add_ovf ? ADD_EXC : sub_ovf ? SUB_EXC : data_result;
        entry.we = exc || entry.rd != '0;
    end
    wb_skid_fifo #(.T(wb_entry)) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (entry),
        .out_valid (wb_valid),
        .out_ready (wb_ready),
        .out_data  (head)
    );
    assign wb_we = wb_valid && head.we;
    assign wb_exc = head.exc;
    assign wb_ne = head.ne;
    assign wb_lt = head.lt;
    assign wb_rd = head.rd;
    assign wb_data = head.data;
    always_ff @(posedge clock) begin
        if (!reset_n) ovf_count <= '0;
        else if (push && exc && !(&ovf_count)) ovf_count <= ovf_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage: directed scoreboard bench for the ALU writeback stage (2-bit counter to reach saturation)
module tb_alu_writeback_stage;
    import alu_pkg::*;
    logic clock = 1'b0;
    logic reset_n, in_valid, in_ready, overflow, isNotEqual, isLessThan;
    logic [4:0] in_opcode, in_rd, wb_rd;
    logic [31:0] data_result, wb_data;
    logic wb_valid, wb_ready, wb_we, wb_ne, wb_lt, wb_exc;
    logic [1:0] ovf_count;
    int checks = 0;
    int errors = 0;
    int cnt_model = 0;
    bit pushed;
    wb_entry q [$];

    always #5 clock = ~clock;

    alu_writeback_stage #(.CNT_W(2)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .data_result(data_result), .overflow(overflow),
        .isNotEqual(isNotEqual), .isLessThan(isLessThan), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ne(wb_ne), .wb_lt(wb_lt),
        .wb_exc(wb_exc), .ovf_count(ovf_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic wb_entry model(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] d,
                                      input logic ov, input logic ne, input logic lt);
        wb_entry e;
        e.exc = ov && (op == 5'd0 || op == 5'd1);
        e.rd = e.exc ? 5'd30 : rd;
        e.data = (ov && op == 5'd0) ? 32'd1 : (ov && op == 5'd1) ? 32'd3 : d;
        e.we = e.exc || rd != 5'd0 && !e.exc || e.exc;
        e.we = e.exc ? 1'b1 : (rd != 5'd0);
        e.ne = ne;
        e.lt = lt;
        return e;
    endfunction

    task automatic tick();
        bit pop;
        @(negedge clock);
        pushed = 1'b0;
        if (!reset_n) begin
            q.delete();
            cnt_model = 0;
        end else begin
            chk("in_ready", in_ready, q.size() != 2);
            chk("wb_valid", wb_valid, q.size() != 0);
            chk("ovf_count", ovf_count, cnt_model);
            if (!wb_valid) chk("wb_we_idle", wb_we, 0);
            if (wb_valid && q.size() > 0) begin
                chk("wb_we", wb_we, q[0].we);
                chk("wb_exc", wb_exc, q[0].exc);
                chk("wb_rd", wb_rd, q[0].rd);
                chk("wb_data", wb_data, q[0].data);
                chk("wb_ne", wb_ne, q[0].ne);
                chk("wb_lt", wb_lt, q[0].lt);
            end
            pop = wb_valid && wb_ready && q.size() > 0;
            pushed = in_valid && in_ready;
            if (pop) void'(q.pop_front());
            if (pushed) begin
                q.push_back(model(in_opcode, in_rd, data_result, overflow, isNotEqual, isLessThan));
                if (q[$].exc && cnt_model != 3) cnt_model++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] d,
                        input logic ov, input logic ne, input logic lt, output int waited);
        in_valid = 1'b1;
        in_opcode = op;
        in_rd = rd;
        data_result = d;
        overflow = ov;
        isNotEqual = ne;
        isLessThan = lt;
        waited = 0;
        do begin
            tick();
            if (!pushed) waited++;
        end while (!pushed && waited < 50);
        if (!pushed) chk("send_timeout", waited, 0);
        in_valid = 1'b0;
    endtask

    initial begin
        int w;
        int sat_seq [5] = '{1, 2, 3, 3, 3};
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_opcode = '0;
        in_rd = '0;
        data_result = '0;
        overflow = 1'b0;
        isNotEqual = 1'b0;
        isLessThan = 1'b0;
        wb_ready = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wb_exc", wb_exc, 0);
        // ADD overflow becomes rstatus write of 1
        send(OP_ADD, 5'd7, 32'h8000_0000, 1'b1, 1'b1, 1'b0, w);
        chk("add_ovf_rd", wb_rd, 30);
        chk("add_ovf_data", wb_data, 1);
        chk("add_ovf_exc", wb_exc, 1);
        chk("add_ovf_cnt", ovf_count, 1);
        tick();
        send(OP_SUB, 5'd9, 32'h7fff_ffff, 1'b1, 1'b0, 1'b1, w);
        send(OP_ADD, 5'd0, 32'd5, 1'b0, 1'b0, 1'b0, w);
        chk("r0_rd", wb_rd, 0);
        chk("r0_data", wb_data, 5);
        chk("r0_we", wb_we, 0);
        tick();
        // Backpressure: third op must wait for space
        wb_ready = 1'b0;
        send(5'd2, 5'd3, 32'h11, 1'b1, 1'b0, 1'b0, w);
        send(5'd2, 5'd4, 32'h22, 1'b0, 1'b0, 1'b0, w);
        chk("bp_full", in_ready, 0);
        in_valid = 1'b1;
        data_result = 32'h33;
        in_rd = 5'd5;
        overflow = 1'b0;
        tick();
        tick();
        chk("bp_head_stable", wb_data, 32'h11);
        wb_ready = 1'b1;
        send(5'd2, 5'd5, 32'h33, 1'b0, 1'b0, 1'b0, w);
        chk("bp_third_waited", w, 1);
        for (int i = 0; i < 4 && q.size() != 0; i++) tick();
        chk("bp_drained", q.size(), 0);
        // Streaming with random ops
        for (int i = 0; i < 100; i++) begin
            send(5'($urandom_range(0, 3)), 5'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), w);
            chk("stream_nowait", w, 0);
            chk("stream_depth", q.size() <= 1, 1);
        end
        tick();
        // Reset mid-stream with two entries buffered
        wb_ready = 1'b0;
        send(OP_ADD, 5'd1, 32'hA, 1'b1, 1'b0, 1'b0, w);
        send(OP_SUB, 5'd2, 32'hB, 1'b1, 1'b0, 1'b0, w);
        chk("pre_rst_full", in_ready, 0);
        in_valid = 1'b1;
        reset_n = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        reset_n = 1'b1;
        wb_ready = 1'b1;
        tick();
        chk("post_rst_valid", wb_valid, 0);
        chk("post_rst_cnt", ovf_count, 0);
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_we", wb_we, 0);
        tick();
        // Saturating counter at 2 bits
        for (int i = 0; i < 5; i++) begin
            send(i[0] ? OP_SUB : OP_ADD, 5'd6, 32'h1234, 1'b1, 1'b0, 1'b0, w);
            chk("sat_seq", ovf_count, sat_seq[i]);
        end
        for (int i = 0; i < 4 && q.size() != 0; i++) tick();
        chk("final_drain", q.size(), 0);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
